clk_div_multi: RTL

- Parametrised N-channel programmable clock divider; successor to the fixed 50 MHz → 1 MHz / 100 kHz divider.
- Each channel has a runtime-writable 16-bit divisor and produces a registered divided clock plus a one-cycle tick strobe for enable-style logic.
- Divisor changes apply glitch-free at the channel's period boundary.
- Sits at the top of the clocking tree and feeds slow peripherals (I2C, UART baud, LED scan).

---
 rtl/clk_div_multi_pkg.sv | 15 +
 rtl/clk_div_multi_if.sv | 26 ++
 rtl/clk_div_multi_chan.sv | 109 ++++++++++
 rtl/clk_div_multi.sv | 46 ++++
 4 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;

  // Default divisor / counter width.
  localparam int W_DEF = 16;

  // Smallest divisor that keeps a channel running; anything below turns it off.
  localparam int DIV_MIN = 2;

  // Number of high cycles in one output period for divisor d (floor(d/2)).
  function automatic logic [31:0] half_period(input logic [31:0] d);
    return d >> 5'd1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor-write bus and per-channel status/clock outputs of clk_div_multi.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int N = 2,
  parameter int W = W_DEF
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic [W-1:0]  wr_div;
  logic [N-1:0]  pend;
  logic [N-1:0]  clk_out;
  logic [N-1:0]  tick;

  modport master (
    output wr_en, wr_ch, wr_div,
    input  pend, clk_out, tick
  );

  modport slave (
    input  wr_en, wr_ch, wr_div,
    output pend, clk_out, tick
  );
endinterface

// File: rtl/clk_div_multi_chan.sv
// One divider channel: period counter, active/pending divisor registers,
// boundary-aligned divisor update and (with CLK_DIV_ODD_DUTY50_EN defined)
// a negedge stage that evens out the duty cycle for odd divisors.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int           W       = W_DEF,
  parameter logic [W-1:0] RST_DIV = W'(500)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_sel_i,
  input  logic [W-1:0] wr_div_i,
  output logic         pend_o,
  output logic         clk_out_o,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         pend_q, pend_d;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;

  logic         active_s;
  logic         last_s;
  logic         bound_s;
  logic [W-1:0] half_s;

  // A divisor below DIV_MIN parks the channel; every edge is then a boundary.
  assign active_s = (div_q >= W'(DIV_MIN));
  assign last_s   = active_s && (cnt_q == (div_q - W'(1)));
  assign bound_s  = !active_s || last_s;
  assign half_s   = W'(half_period(32'(div_q)));

  // Next-state: count, and swap in a new divisor only at a period boundary.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    clk_out_d  = active_s && (cnt_q < half_s);
    tick_d     = last_s;
    if (bound_s) begin
      cnt_d = W'(0);
      if (wr_sel_i) begin
        // A write landing on the boundary wins over any older pending value.
        div_d  = wr_div_i;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = pend_div_q;
        pend_d = 1'b0;
      end else begin
        div_d  = div_q;
      end
    end else begin
      cnt_d = cnt_q + W'(1);
      if (wr_sel_i) begin
        // Last write before the boundary wins.
        pend_div_d = wr_div_i;
        pend_d     = 1'b1;
      end else begin
        pend_div_d = pend_div_q;
      end
    end
  end

  // Channel state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= W'(0);
      div_q      <= RST_DIV;
      pend_div_q <= W'(0);
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign tick_o = tick_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle delayed copy of the divided clock for odd-divisor stretching.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= clk_out_q;
    end
  end

  // Odd divisors get their high phase extended by half a clk cycle.
  assign clk_out_o = div_q[0] ? (clk_out_q | neg_q) : clk_out_q;
`else
  assign clk_out_o = clk_out_q;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider top: decodes divisor writes to the
// addressed channel and instantiates one clk_div_chan per channel.
// Optional build macro: CLK_DIV_ODD_DUTY50_EN (50% duty for odd divisors).
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int             N       = 2,
  parameter int             W       = W_DEF,
  parameter logic [N*W-1:0] DIV_RST = {16'd500, 16'd50}
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_multi_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] pend_s;
  logic [N-1:0] clk_out_s;
  logic [N-1:0] tick_s;

  // Channel numbers >= N match no instance, so such writes are dropped.
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic wr_sel_s;

    assign wr_sel_s = bus.wr_en && (bus.wr_ch == CW'(i));

    clk_div_chan #(
      .W       (W),
      .RST_DIV (DIV_RST[i*W +: W])
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wr_sel_i  (wr_sel_s),
      .wr_div_i  (bus.wr_div),
      .pend_o    (pend_s[i]),
      .clk_out_o (clk_out_s[i]),
      .tick_o    (tick_s[i])
    );
  end

  assign bus.pend    = pend_s;
  assign bus.clk_out = clk_out_s;
  assign bus.tick    = tick_s;

endmodule
